// File: rtl/mlclaa_16bit_adder.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups feed a
// second-level carry unit; combinational sum/cout plus a registered copy.
module mlclaa_16bit_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cin,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        cout,
    output logic [15:0] sum_q,
    output logic        cout_q
);

    localparam int NUM_GRP = 4;
    localparam int GRP_W   = 4;

    logic [15:0]        g;
    logic [15:0]        p;
    logic [15:0]        carry;
    logic [NUM_GRP-1:0] grp_g;
    logic [NUM_GRP-1:0] grp_p;
    logic [NUM_GRP:0]   grp_c;

    assign g = a & b;
    assign p = a ^ b;

    // Level 1: each group expands its internal carries from its own carry-in.
    for (genvar k = 0; k < NUM_GRP; k++) begin : g_grp
        logic [GRP_W-1:0] gl;
        logic [GRP_W-1:0] pl;
        logic             ci;

        assign gl = g[k*GRP_W +: GRP_W];
        assign pl = p[k*GRP_W +: GRP_W];
        assign ci = grp_c[k];

        assign carry[k*GRP_W + 0] = ci;
        assign carry[k*GRP_W + 1] = gl[0]
                                  | (pl[0] & ci);
        assign carry[k*GRP_W + 2] = gl[1]
                                  | (pl[1] & gl[0])
                                  | (pl[1] & pl[0] & ci);
        assign carry[k*GRP_W + 3] = gl[2]
                                  | (pl[2] & gl[1])
                                  | (pl[2] & pl[1] & gl[0])
                                  | (pl[2] & pl[1] & pl[0] & ci);

        assign grp_g[k] = gl[3]
                        | (pl[3] & gl[2])
                        | (pl[3] & pl[2] & gl[1])
                        | (pl[3] & pl[2] & pl[1] & gl[0]);
        assign grp_p[k] = &pl;
    end

    // Level 2: group carry-ins and final carry, fully expanded from cin.
    assign grp_c[0] = cin;
    assign grp_c[1] = grp_g[0]
                    | (grp_p[0] & cin);
    assign grp_c[2] = grp_g[1]
                    | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & cin);
    assign grp_c[3] = grp_g[2]
                    | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    assign grp_c[4] = grp_g[3]
                    | (grp_p[3] & grp_g[2])
                    | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

    assign sum  = p ^ carry;
    assign cout = grp_c[NUM_GRP];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
        end
    end

endmodule

// File: tb/tb_mlclaa_16bit_adder.sv
// Scoreboarded bench: driver queues expected results, negedge monitor compares.
module tb_mlclaa_16bit_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] sum;
    logic        cout;
    logic [15:0] sum_q;
    logic        cout_q;

    mlclaa_16bit_adder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .sum    (sum),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q)
    );

    always #5 clk = ~clk;

    logic [16:0] comb_q[$];
    logic [16:0] reg_q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [16:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                          input logic tc);
        return 17'(ta) + 17'(tb) + 17'(tc);
    endfunction

    task automatic apply(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic tr, input logic [16:0] expv);
        @(posedge clk);
        #1;
        a = ta; b = tb; cin = tc; rst_n = tr;
        comb_q.push_back(expv);
        reg_q.push_back(tr ? expv : 17'h0);
    endtask

    // Registered result seen at a negedge belongs to the previous cycle's inputs.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reg_q.size() > 1) begin
            e = reg_q.pop_front();
            vectors++;
            if ({cout_q, sum_q} !== e) begin
                miscompares++;
                $display("FAIL reg_path: got cout_q=%b sum_q=%h, want cout_q=%b sum_q=%h",
                         cout_q, sum_q, e[16], e[15:0]);
            end
        end
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            vectors++;
            if ({cout, sum} !== e) begin
                miscompares++;
                $display("FAIL comb_path: a=%h b=%h cin=%b got cout=%b sum=%h, want cout=%b sum=%h",
                         a, b, cin, cout, sum, e[16], e[15:0]);
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rc;

        // Reset held: comb path must still add; registers must read zero.
        apply(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000);
        apply(16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001);
        apply(16'h1234, 16'h4321, 1'b1, 1'b1, 17'h05556);
        apply(16'h0000, 16'h0000, 1'b0, 1'b1, 17'h00000);
        apply(16'h0000, 16'h0000, 1'b1, 1'b1, 17'h00001);
        apply(16'hFFFF, 16'h0000, 1'b1, 1'b1, 17'h10000);
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h1FFFF);
        apply(16'h000F, 16'h0001, 1'b0, 1'b1, 17'h00010);
        apply(16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h00100);
        apply(16'h0FFF, 16'h0001, 1'b0, 1'b1, 17'h01000);
        apply(16'h8000, 16'h8000, 1'b0, 1'b1, 17'h10000);
        apply(16'hAAAA, 16'h5555, 1'b1, 1'b1, 17'h10000);
        apply(16'hAAAA, 16'h5555, 1'b0, 1'b1, 17'h0FFFF);
        // Mid-run reset: cout_q goes 1 then is cleared while comb cout stays 1.
        apply(16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h10000);
        apply(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
        apply(16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h10000);

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i % 997 == 5) rb = ~ra;
            apply(ra, rb, rc, (i % 1500 != 700), model(ra, rb, rc));
        end

        apply(16'h0000, 16'h0000, 1'b0, 1'b1, 17'h00000);
        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (comb_q.size() != 0 || reg_q.size() != 1) begin
            miscompares++;
            $display("FAIL drain: comb_q=%0d reg_q=%0d, want 0 and 1", comb_q.size(), reg_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mlclaa_16bit_adder.md
Name: mlclaa_16bit_adder

Overview:
- 16-bit two-level (multi-level) carry-lookahead adder: computes a + b + cin.
- Primary sum/carry outputs are purely combinational (zero latency) for use inside wider datapaths such as IDDMM word adders.
- A registered copy of the result is also provided, clocked by the block's single clock and cleared by synchronous active-low reset.

Parameters:
- none (width fixed at 16; 4 groups of 4 bits)

Ports:
- clk    input   1   system clock; rising-edge active
- rst_n  input   1   synchronous, active-low reset; sampled on rising clk edge
- cin    input   1   carry-in
- a      input   16  addend A, unsigned
- b      input   16  addend B, unsigned
- sum    output  16  combinational sum, equal to (a + b + cin) mod 2^16
- cout   output  1   combinational carry-out, bit 16 of a + b + cin
- sum_q  output  16  registered sum
- cout_q output  1   registered carry-out

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). The polarity and synchronicity are fixed.
- Combinational path: {cout, sum} = a + b + cin, exact 17-bit result, for all 2^33 input combinations.
  - sum and cout settle within the same cycle.
  - They do not depend on clk or rst_n; reset does not force them.
- Bit level, for i = 0..15:
  - generate g_i = a_i & b_i
  - propagate p_i = a_i ^ b_i
- Level 1: four 4-bit CLA groups (bits 3:0, 7:4, 11:8, 15:12).
  - Each group computes its internal carries from its group carry-in using lookahead equations (c_{i+1} = g_i | p_i & c_i, fully expanded; no ripple).
  - Each group outputs group generate GG = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Each group outputs group propagate GP = p3p2p1p0.
- Level 2: a lookahead carry unit computes group carry-ins c4, c8, c12 and the final c16 from cin and the four (GG, GP) pairs, fully expanded.
- cout = c16 = GG3 | GP3·GG2 | GP3·GP2·GG1 | GP3·GP2·GP1·GG0 | GP3·GP2·GP1·GP0·cin.
- sum_i = p_i ^ c_i, with c_0 = cin.
- The core adder must be built from the g/p lookahead structure. A behavioural "+" operator is not permitted in the core.
- Registered path, on each rising clk edge:
  - if rst_n == 0: sum_q <= 0, cout_q <= 0
  - else: sum_q <= sum, cout_q <= cout
  - Latency is 1 cycle. There is no enable; the registers update every cycle.
- Reset-state values: sum_q = 16'h0000, cout_q = 0. Before the first clk edge, sum_q and cout_q are undefined.
- Reset asserted mid-operation clears sum_q/cout_q on the next edge only. It does not affect the combinational outputs.
- Boundary cases:
  - Full-propagate chain (a ^ b = 16'hFFFF): the carry passes from cin straight to cout through the GP terms.
  - Wrap-around: the result is taken mod 2^16 and the overflow appears on cout.

Test Plan:
- a=16'h0000, b=16'h0000, cin=0 -> sum=16'h0000, cout=0. Then cin=1 -> sum=16'h0001, cout=0.
- a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1 (full propagate). Then a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
- Group-boundary carries: a=16'h000F, b=16'h0001, cin=0 -> sum=16'h0010 (c4). a=16'h0FFF, b=16'h0001, cin=0 -> sum=16'h1000 (c12). a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, cout=1.
- Random regression: 10000 random (a, b, cin), new values each rising clk. At each falling edge check {cout, sum} == a+b+cin as a 17-bit result; zero mismatches.
- Registered path: rst_n=0 for 2 cycles -> sum_q=0, cout_q=0. Release, apply a=16'h1234, b=16'h4321, cin=1 -> after next rising edge, sum_q=16'h5556, cout_q=0.
- Mid-run reset: with a=16'hFFFF, b=16'h0001 (sum=0, cout=1) and cout_q=1, drop rst_n for one edge -> cout_q=0 and sum_q=0, while combinational cout stays 1.
